universal_shift_register: RTL and testbench
===========================================

# universal_shift_register

Parametrised N-bit register that generalises the single D flip-flop into a multi-mode storage element: hold, parallel load, logical shift left/right with serial input, rotate left/right, and binary up/down count. It is the storage building block for the sequential-logic labs (counters, serial links, pattern generators). It is built from an array of async-reset D flip-flop cells behind a per-bit next-state mux, and it exposes both true and complemented outputs.

## Interface
- WIDTH, 8, register width in bits (≥ 2)
- RESET_VALUE, 0, value loaded into Q on reset (WIDTH bits)
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  clock enable; when 0, Q holds regardless of mode
- mode  input  3  operation select (encoding below)
- D  input  WIDTH  parallel load data
- sin  input  1  serial input for shift modes
- Q  output  WIDTH  register contents
- notQ  output  WIDTH  bitwise complement of Q
- sout  output  1  bit shifted out in the last shift/rotate cycle
- tc  output  1  terminal count: Q all ones in mode 110, or Q all zeros in mode 111; 0 in other modes

## Operation
- Mode encoding, evaluated only when en=1:
  - 000: hold
  - 001: shift right, Q <= {sin, Q[WIDTH-1:1]}, sout <= Q[0]
  - 010: shift left, Q <= {Q[WIDTH-2:0], sin}, sout <= Q[WIDTH-1]
  - 011: parallel load, Q <= D
  - 100: rotate right, Q <= {Q[0], Q[WIDTH-1:1]}, sout <= Q[0]
  - 101: rotate left, Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}, sout <= Q[WIDTH-1]
  - 110: count up, Q <= Q + 1, modulo 2^WIDTH
  - 111: count down, Q <= Q - 1, modulo 2^WIDTH
- sout is registered. It updates only in modes 001, 010, 100 and 101 with en=1; otherwise it holds.
- Arithmetic is unsigned, WIDTH bits, and wraps: all ones + 1 → 0, 0 − 1 → all ones. No carry-out port; tc is the wrap indicator.
- notQ is combinational from Q. notQ == ~Q at all times, including during reset.
- tc is combinational from Q and mode, with no en qualification. It is asserted in the cycle before the wrap when en=1.

## Timing
- Reset: rst=1 asynchronously forces Q=RESET_VALUE, notQ=~RESET_VALUE and sout=0. tc follows Q and mode.
- Reset is effective immediately, without waiting for a clock edge, and overrides en and mode.
- Reset release: the first capturing edge is the first rising clk edge with rst=0.
- Asserting rst mid-operation (mid-count or mid-shift) abandons the operation. No partial result survives.
- Latency: one cycle. Inputs sampled at rising edge k are visible on Q after edge k.
- Mode or D may change every cycle. The mode value sampled at the edge decides the operation; there is no pipelining.
- en=0 at an edge: Q and sout are unchanged. tc still reflects the current Q and mode.

## Structure
- Package usr_pkg holds:
  - the mode_t 3-bit enum: MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD, MODE_ROR, MODE_ROL, MODE_INC, MODE_DEC
  - the default WIDTH localparam
- Sub-module dff_ar is a 1-bit D flip-flop with asynchronous active-high reset, a reset value input and ports clk/rst/D/Q/notQ. It is instantiated WIDTH times via generate, plus once for sout.
- The top level holds only the next-state mux (case on mode, gated by en) and the tc logic.

## Test plan
- Reset, WIDTH=8, RESET_VALUE=8'hA5: assert rst between clock edges → Q=8'hA5 and notQ=8'h5A without waiting for an edge; sout=0. Release rst → first edge captures normally.
- Load then shift right, serial input 1: load D=8'b1000_0001 (mode 011), then shift right (mode 001) with sin=1 for 3 cycles.
  - Q sequence: 8'hC0, 8'hE0, 8'hF0.
  - sout sequence: 1, 0, 0.
- Load then rotate left: load 8'h81, then rotate left (mode 101) for 2 cycles.
  - Q: 8'h03, then 8'h06.
  - sout: 1, then 0.
- Count-up wrap: load 8'hFE, then count up (mode 110).
  - Q: 8'hFF with tc=1, then 8'h00 with tc=0.
  - Count down (mode 111) from 8'h00 → tc=1 before the edge; Q=8'hFF after it.
- Enable gating: en=0 in mode 110 for 5 cycles → Q and sout unchanged. Set en=1 → Q increments on the next edge.
- Reset mid-operation: counting up at Q=8'h37, pulse rst for 3 ns between edges → Q=RESET_VALUE immediately; counting resumes from RESET_VALUE+1 after release. Check notQ == ~Q on every cycle.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types and defaults for the universal shift register.
package usr_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHR  = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_LOAD = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_ROL  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_t;

endpackage

// File: rtl/universal_shift_register_dff_ar.sv
// Single D flip-flop with asynchronous active-high reset to a per-cell value.
module dff_ar (
  input  logic clk,
  input  logic rst,
  input  logic rv,
  input  logic D,
  output logic Q,
  output logic notQ
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) Q <= rv;
    else     Q <= D;
  end

  assign notQ = ~Q;

endmodule

// File: rtl/universal_shift_register.sv
// Multi-mode register: hold, load, shift, rotate and up/down count over an
// array of async-reset flip-flop cells, with true/complement outputs.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int unsigned      WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             sin,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] notQ,
  output logic             sout,
  output logic             tc
);

  mode_t            op;
  logic [WIDTH-1:0] q_next;
  logic             sout_next;
  logic             sout_n;

  assign op = mode_t'(mode);

  // The sout hold path uses the cell's complement output, so both cell outputs are consumed.
  always_comb begin
    q_next    = Q;
    sout_next = ~sout_n;
    if (en) begin
      case (op)
        MODE_HOLD: ;
        MODE_SHR: begin
          q_next    = {sin, Q[WIDTH-1:1]};
          sout_next = Q[0];
        end
        MODE_SHL: begin
          q_next    = {Q[WIDTH-2:0], sin};
          sout_next = Q[WIDTH-1];
        end
        MODE_LOAD: q_next = D;
        MODE_ROR: begin
          q_next    = {Q[0], Q[WIDTH-1:1]};
          sout_next = Q[0];
        end
        MODE_ROL: begin
          q_next    = {Q[WIDTH-2:0], Q[WIDTH-1]};
          sout_next = Q[WIDTH-1];
        end
        MODE_INC: q_next = Q + 1'b1;
        MODE_DEC: q_next = Q - 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    tc = 1'b0;
    if (op == MODE_INC) tc = &Q;
    if (op == MODE_DEC) tc = ~|Q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_ar u_bit (
      .clk  (clk),
      .rst  (rst),
      .rv   (RESET_VALUE[i]),
      .D    (q_next[i]),
      .Q    (Q[i]),
      .notQ (notQ[i])
    );
  end

  dff_ar u_sout (
    .clk  (clk),
    .rst  (rst),
    .rv   (1'b0),
    .D    (sout_next),
    .Q    (sout),
    .notQ (sout_n)
  );

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=8, RESET_VALUE=8'hA5).
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int unsigned W  = 8;
  localparam logic [W-1:0] RV = 8'hA5;

  logic         clk, rst, en, sin;
  logic [2:0]   mode;
  logic [W-1:0] D, Q, notQ;
  logic         sout, tc;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  logic [W-1:0] m_q;
  logic         m_sout;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .D(D), .sin(sin),
    .Q(Q), .notQ(notQ), .sout(sout), .tc(tc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic model_tc(input logic [W-1:0] q, input logic [2:0] m);
    return (m == 3'd6 && q == {W{1'b1}}) || (m == 3'd7 && q == '0);
  endfunction

  // Advance one clock edge and update the reference from the sampled inputs.
  task automatic tick();
    int unsigned qv;
    @(posedge clk);
    qv = int'(m_q);
    if (rst) begin
      m_q = RV; m_sout = 1'b0;
    end else if (en) begin
      case (mode)
        3'd1: begin m_sout = qv[0];   m_q = W'((qv >> 1) + (int'(sin) << (W-1))); end
        3'd2: begin m_sout = qv[W-1]; m_q = W'((qv * 2) + int'(sin)); end
        3'd3: m_q = D;
        3'd4: begin m_sout = qv[0];   m_q = W'((qv >> 1) + ((qv % 2) << (W-1))); end
        3'd5: begin m_sout = qv[W-1]; m_q = W'((qv * 2) + (qv >> (W-1))); end
        3'd6: m_q = W'((qv + 1) % (1 << W));
        3'd7: m_q = W'((qv + (1 << W) - 1) % (1 << W));
        default: ;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; mode = MODE_HOLD; D = '0; sin = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_q = RV; m_sout = 1'b0;
    n_checks++; if (Q !== 8'hA5) begin n_fail++; $display("FAIL reset_q: got %h want a5", Q); end
    n_checks++; if (notQ !== 8'h5A) begin n_fail++; $display("FAIL reset_notq: got %h want 5a", notQ); end
    n_checks++; if (sout !== 1'b0) begin n_fail++; $display("FAIL reset_sout: got %b want 0", sout); end
    n_checks++; if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc: got %b want 0", tc); end
    en = 1'b1; mode = MODE_INC;
    tick();
    n_checks++; if (Q !== 8'hA5) begin n_fail++; $display("FAIL reset_held: got %h want a5", Q); end
    rst = 1'b0; mode = MODE_LOAD; D = 8'h3C;
    tick();
    n_checks++; if (Q !== 8'h3C) begin n_fail++; $display("FAIL reset_release_load: got %h want 3c", Q); end
  endtask

  task automatic test_shift_right();
    logic [W-1:0] exp_q [3] = '{8'hC0, 8'hE0, 8'hF0};
    logic         exp_s [3] = '{1'b1, 1'b0, 1'b0};
    en = 1'b1; mode = MODE_LOAD; D = 8'b1000_0001;
    tick();
    mode = MODE_SHR; sin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (Q !== exp_q[i]) begin n_fail++; $display("FAIL shr_q[%0d]: got %h want %h", i, Q, exp_q[i]); end
      n_checks++; if (sout !== exp_s[i]) begin n_fail++; $display("FAIL shr_sout[%0d]: got %b want %b", i, sout, exp_s[i]); end
    end
  endtask

  task automatic test_rotate_left();
    logic [W-1:0] exp_q [2] = '{8'h03, 8'h06};
    logic         exp_s [2] = '{1'b1, 1'b0};
    mode = MODE_LOAD; D = 8'h81; sin = 1'b0;
    tick();
    mode = MODE_ROL;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (Q !== exp_q[i]) begin n_fail++; $display("FAIL rol_q[%0d]: got %h want %h", i, Q, exp_q[i]); end
      n_checks++; if (sout !== exp_s[i]) begin n_fail++; $display("FAIL rol_sout[%0d]: got %b want %b", i, sout, exp_s[i]); end
    end
  endtask

  task automatic test_count_wrap();
    mode = MODE_LOAD; D = 8'hFE;
    tick();
    mode = MODE_INC;
    tick();
    n_checks++; if (Q !== 8'hFF || tc !== 1'b1) begin n_fail++; $display("FAIL inc_ff: got q=%h tc=%b want q=ff tc=1", Q, tc); end
    tick();
    n_checks++; if (Q !== 8'h00 || tc !== 1'b0) begin n_fail++; $display("FAIL inc_wrap: got q=%h tc=%b want q=00 tc=0", Q, tc); end
    n_checks++; if (notQ !== 8'hFF) begin n_fail++; $display("FAIL inc_notq: got %h want ff", notQ); end
    mode = MODE_DEC;
    #1;
    n_checks++; if (tc !== 1'b1) begin n_fail++; $display("FAIL dec_tc_pre: got %b want 1", tc); end
    tick();
    n_checks++; if (Q !== 8'hFF || tc !== 1'b0) begin n_fail++; $display("FAIL dec_wrap: got q=%h tc=%b want q=ff tc=0", Q, tc); end
  endtask

  task automatic test_enable();
    logic [W-1:0] q0;
    logic         s0;
    mode = MODE_SHL; sin = 1'b1;
    tick();
    q0 = m_q; s0 = m_sout;
    en = 1'b0; mode = MODE_INC;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (Q !== q0 || sout !== s0) begin n_fail++; $display("FAIL en_hold[%0d]: got q=%h s=%b want q=%h s=%b", i, Q, sout, q0, s0); end
      n_checks++; if (tc !== model_tc(q0, mode)) begin n_fail++; $display("FAIL en_tc[%0d]: got %b want %b", i, tc, model_tc(q0, mode)); end
    end
    en = 1'b1;
    tick();
    n_checks++; if (Q !== q0 + 8'd1) begin n_fail++; $display("FAIL en_resume: got %h want %h", Q, q0 + 8'd1); end
  endtask

  task automatic test_reset_mid();
    mode = MODE_LOAD; D = 8'h36;
    tick();
    mode = MODE_INC;
    tick();
    n_checks++; if (Q !== 8'h37) begin n_fail++; $display("FAIL mid_pre: got %h want 37", Q); end
    #2 rst = 1'b1;
    #1;
    m_q = RV; m_sout = 1'b0;
    n_checks++; if (Q !== RV || notQ !== ~RV) begin n_fail++; $display("FAIL mid_async: got q=%h nq=%h want q=%h nq=%h", Q, notQ, RV, ~RV); end
    #2 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (Q !== RV + W'(i)) begin n_fail++; $display("FAIL mid_resume[%0d]: got %h want %h", i, Q, RV + W'(i)); end
      n_checks++; if (notQ !== ~Q) begin n_fail++; $display("FAIL mid_notq[%0d]: got %h want %h", i, notQ, ~Q); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en   = ($urandom_range(0, 7) != 0);
      mode = 3'($urandom_range(0, 7));
      D    = 8'($urandom);
      sin  = 1'($urandom);
      tick();
      n_checks++; if (Q !== m_q || sout !== m_sout) begin n_fail++; $display("FAIL rand_state[%0d]: got q=%h s=%b want q=%h s=%b", i, Q, sout, m_q, m_sout); end
      n_checks++; if (notQ !== ~m_q || tc !== model_tc(m_q, mode)) begin n_fail++; $display("FAIL rand_comb[%0d]: got nq=%h tc=%b want nq=%h tc=%b", i, notQ, tc, ~m_q, model_tc(m_q, mode)); end
      if ($urandom_range(0, 24) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        m_q = RV; m_sout = 1'b0;
        n_checks++; if (Q !== RV || sout !== 1'b0) begin n_fail++; $display("FAIL rand_rst[%0d]: got q=%h s=%b want q=%h s=0", i, Q, sout, RV); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_right();
    test_rotate_left();
    test_count_wrap();
    test_enable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
